// File: rtl/fifo_sync_prog.sv
// fifo_sync_prog
// Single-clock FIFO with programmable almost-empty / almost-full thresholds,
// occupancy count and sticky overflow / underflow error flags.
//
// Ports:
//   CLK   - clock, all state changes on the rising edge
//   RS    - asynchronous active-low reset
//   D     - write data, or offset value when LD=0
//   WEN   - write enable, active-low
//   REN   - read enable, active-low
//   LD    - offset-load select, active-low
//   OE    - output enable, Q forced to 0 while low
//   Q     - read data (registered in standard mode, head word in FWFT mode)
//   EF/FF - empty / full flags
//   PAE   - programmable almost-empty flag
//   PAF   - programmable almost-full flag
//   COUNT - words stored, 0..DEPTH
//   OVF   - sticky overflow error
//   UDF   - sticky underflow error
module fifo_sync_prog #(
  parameter int WIDTH       = 9,
  parameter int DEPTH       = 256,
  parameter int ADDR_WIDTH  = 8,
  parameter int FWFT        = 0,
  parameter int PAE_DEFAULT = 7,
  parameter int PAF_DEFAULT = 7
) (
  input  logic                  CLK,
  input  logic                  RS,
  input  logic [WIDTH-1:0]      D,
  input  logic                  WEN,
  input  logic                  REN,
  input  logic                  LD,
  input  logic                  OE,
  output logic [WIDTH-1:0]      Q,
  output logic                  EF,
  output logic                  FF,
  output logic                  PAE,
  output logic                  PAF,
  output logic [ADDR_WIDTH:0]   COUNT,
  output logic                  OVF,
  output logic                  UDF
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_C    = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_ZERO_C = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE_C  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] PTR_ZERO_C = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE_C  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] PAE_RST_C  = ADDR_WIDTH'(PAE_DEFAULT);
  localparam logic [ADDR_WIDTH-1:0] PAF_RST_C  = ADDR_WIDTH'(PAF_DEFAULT);
  localparam logic [WIDTH-1:0]      Q_ZERO_C   = {WIDTH{1'b0}};
  localparam bit                    FWFT_C     = (FWFT != 0);

  logic [WIDTH-1:0]      mem_r [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_r;
  logic [ADDR_WIDTH-1:0] rd_ptr_r;
  logic [ADDR_WIDTH:0]   count_r;
  logic [WIDTH-1:0]      q_r;
  logic                  sel_r;
  logic [ADDR_WIDTH-1:0] pae_off_r;
  logic [ADDR_WIDTH-1:0] paf_off_r;
  logic                  ef_r;
  logic                  ff_r;
  logic                  pae_r;
  logic                  paf_r;
  logic                  ovf_r;
  logic                  udf_r;

  logic                  wr_acc_s;
  logic                  rd_acc_s;
  logic                  ld_acc_s;
  logic [ADDR_WIDTH:0]   count_next_s;
  logic [ADDR_WIDTH:0]   paf_thr_s;
  logic [WIDTH-1:0]      head_s;
  logic [WIDTH-1:0]      q_int_s;

  // Accept decisions from pre-edge state, next count and PAF threshold.
  always_comb begin
    wr_acc_s  = (!WEN) && LD && (count_r != DEPTH_C);
    rd_acc_s  = (!REN) && (count_r != CNT_ZERO_C);
    ld_acc_s  = (!WEN) && (!LD);
    head_s    = mem_r[rd_ptr_r];
    // paf_off is at most DEPTH-1, so the threshold never underflows.
    paf_thr_s = DEPTH_C - {1'b0, paf_off_r};
    if (wr_acc_s && !rd_acc_s) begin
      count_next_s = count_r + CNT_ONE_C;
    end else if (rd_acc_s && !wr_acc_s) begin
      count_next_s = count_r - CNT_ONE_C;
    end else begin
      count_next_s = count_r;
    end
  end

  // Storage array; not reset, contents are only meaningful between pointers.
  always_ff @(posedge CLK) begin
    if (wr_acc_s) begin
      mem_r[wr_ptr_r] <= D;
    end
  end

  // Pointers, count, read register, offsets, flags and error bits.
  always_ff @(posedge CLK or negedge RS) begin
    if (!RS) begin
      wr_ptr_r  <= PTR_ZERO_C;
      rd_ptr_r  <= PTR_ZERO_C;
      count_r   <= CNT_ZERO_C;
      q_r       <= Q_ZERO_C;
      sel_r     <= 1'b0;
      pae_off_r <= PAE_RST_C;
      paf_off_r <= PAF_RST_C;
      ef_r      <= 1'b1;
      ff_r      <= 1'b0;
      pae_r     <= 1'b1;
      paf_r     <= 1'b0;
      ovf_r     <= 1'b0;
      udf_r     <= 1'b0;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
      end
      if (rd_acc_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
      end
      count_r <= count_next_s;

      // Standard mode loads on a pop; FWFT mode shadows the visible head so
      // Q keeps its last value once the FIFO runs empty.
      if (FWFT_C) begin
        if (count_r != CNT_ZERO_C) begin
          q_r <= head_s;
        end
      end else if (rd_acc_s) begin
        q_r <= head_s;
      end

      // Offset loads alternate PAE, PAF; any LD=1 cycle rearms PAE first.
      if (ld_acc_s) begin
        if (sel_r) begin
          paf_off_r <= D[ADDR_WIDTH-1:0];
        end else begin
          pae_off_r <= D[ADDR_WIDTH-1:0];
        end
        sel_r <= ~sel_r;
      end else if (LD) begin
        sel_r <= 1'b0;
      end

      ef_r  <= (count_next_s == CNT_ZERO_C);
      ff_r  <= (count_next_s == DEPTH_C);
      pae_r <= (count_next_s <= {1'b0, pae_off_r});
      paf_r <= (count_next_s >= paf_thr_s);

      // A read at full frees a slot, so only an unpaired write is an overflow.
      if ((!WEN) && LD && (count_r == DEPTH_C) && !rd_acc_s) begin
        ovf_r <= 1'b1;
      end
      if ((!REN) && (count_r == CNT_ZERO_C)) begin
        udf_r <= 1'b1;
      end
    end
  end

  // Output data select and combinational output-enable gate.
  always_comb begin
    if (FWFT_C && (count_r != CNT_ZERO_C)) begin
      q_int_s = head_s;
    end else begin
      q_int_s = q_r;
    end
    if (OE) begin
      Q = q_int_s;
    end else begin
      Q = Q_ZERO_C;
    end
  end

  assign EF    = ef_r;
  assign FF    = ff_r;
  assign PAE   = pae_r;
  assign PAF   = paf_r;
  assign COUNT = count_r;
  assign OVF   = ovf_r;
  assign UDF   = udf_r;

endmodule

// File: tb/tb_fifo_sync_prog.sv
// Directed bench for fifo_sync_prog, WIDTH=9, DEPTH=16. A standard-mode and
// an FWFT instance share all inputs; the FWFT one is checked at the end.
module tb_fifo_sync_prog;

  logic       CLK;
  logic       RS;
  logic [8:0] D;
  logic       WEN;
  logic       REN;
  logic       LD;
  logic       OE;

  logic [8:0] q;
  logic       ef, ff, pae, paf, ovf, udf;
  logic [4:0] count;
  logic [8:0] qf;
  logic       eff, fff, paef, paff, ovff, udff;
  logic [4:0] countf;

  int checks = 0;
  int errors = 0;

  fifo_sync_prog #(.WIDTH(9), .DEPTH(16), .ADDR_WIDTH(4), .FWFT(0),
                   .PAE_DEFAULT(7), .PAF_DEFAULT(7)) dut (
    .CLK(CLK), .RS(RS), .D(D), .WEN(WEN), .REN(REN), .LD(LD), .OE(OE),
    .Q(q), .EF(ef), .FF(ff), .PAE(pae), .PAF(paf), .COUNT(count),
    .OVF(ovf), .UDF(udf));

  fifo_sync_prog #(.WIDTH(9), .DEPTH(16), .ADDR_WIDTH(4), .FWFT(1),
                   .PAE_DEFAULT(7), .PAF_DEFAULT(7)) dut_f (
    .CLK(CLK), .RS(RS), .D(D), .WEN(WEN), .REN(REN), .LD(LD), .OE(OE),
    .Q(qf), .EF(eff), .FF(fff), .PAE(paef), .PAF(paff), .COUNT(countf),
    .OVF(ovff), .UDF(udff));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic       wen, ren, ld;
    logic [8:0] d;
    logic [4:0] cnt;
    logic       ef, ff, pae, paf, ovf, udf;
    logic [8:0] q;
  } vec_t;

  vec_t tbl [34];

  function automatic vec_t mk(input logic wen, input logic ren, input logic ld,
                              input logic [8:0] d, input logic [4:0] cnt,
                              input logic e, input logic f, input logic pe,
                              input logic pf, input logic ov, input logic ud,
                              input logic [8:0] qq);
    vec_t v;
    v.wen = wen; v.ren = ren; v.ld = ld; v.d = d; v.cnt = cnt;
    v.ef = e; v.ff = f; v.pae = pe; v.paf = pf; v.ovf = ov; v.udf = ud;
    v.q = qq;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs and sample 1 time unit after the edge.
  task automatic step(input logic wen, input logic ren, input logic ld, input logic [8:0] d);
    WEN = wen; REN = ren; LD = ld; D = d;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // Fill to full, one overflow write, drain, one underflow read.
    for (int i = 0; i < 16; i++)
      tbl[i] = mk(1'b0, 1'b1, 1'b1, 9'(256 + i), 5'(i + 1), 1'b0, (i == 15),
                  ((i + 1) <= 7), ((i + 1) >= 9), 1'b0, 1'b0, 9'h000);
    tbl[16] = mk(1'b0, 1'b1, 1'b1, 9'h1AA, 5'd16, 1'b0, 1'b1, 1'b0, 1'b1,
                 1'b1, 1'b0, 9'h000);
    for (int j = 0; j < 16; j++)
      tbl[17 + j] = mk(1'b1, 1'b0, 1'b1, 9'h000, 5'(15 - j), (j == 15), 1'b0,
                       ((15 - j) <= 7), ((15 - j) >= 9), 1'b1, 1'b0, 9'(256 + j));
    tbl[33] = mk(1'b1, 1'b0, 1'b1, 9'h000, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0,
                 1'b1, 1'b1, 9'h10F);

    RS = 1'b0; WEN = 1'b1; REN = 1'b1; LD = 1'b1; OE = 1'b1; D = 9'h000;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst count", 16'(count), 16'd0);
    chk("rst ef",    16'(ef),    16'd1);
    chk("rst ff",    16'(ff),    16'd0);
    chk("rst pae",   16'(pae),   16'd1);
    chk("rst paf",   16'(paf),   16'd0);
    chk("rst ovf",   16'(ovf),   16'd0);
    chk("rst udf",   16'(udf),   16'd0);
    chk("rst q",     16'(q),     16'd0);
    RS = 1'b1;

    for (int k = 0; k < 34; k++) begin
      step(tbl[k].wen, tbl[k].ren, tbl[k].ld, tbl[k].d);
      chk($sformatf("vec%0d count", k), 16'(count), 16'(tbl[k].cnt));
      chk($sformatf("vec%0d ef", k),    16'(ef),    16'(tbl[k].ef));
      chk($sformatf("vec%0d ff", k),    16'(ff),    16'(tbl[k].ff));
      chk($sformatf("vec%0d pae", k),   16'(pae),   16'(tbl[k].pae));
      chk($sformatf("vec%0d paf", k),   16'(paf),   16'(tbl[k].paf));
      chk($sformatf("vec%0d ovf", k),   16'(ovf),   16'(tbl[k].ovf));
      chk($sformatf("vec%0d udf", k),   16'(udf),   16'(tbl[k].udf));
      chk($sformatf("vec%0d q", k),     16'(q),     16'(tbl[k].q));
    end

    // Mid-run reset with 5 words stored and a non-zero Q register.
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b1, 9'(9'h050 + i));
    step(1'b1, 1'b0, 1'b1, 9'h000);
    chk("pre-rst count", 16'(count), 16'd5);
    chk("pre-rst q",     16'(q),     16'h050);
    WEN = 1'b1; REN = 1'b1;
    RS = 1'b0;
    #1;
    chk("midrst count", 16'(count), 16'd0);
    chk("midrst ef",    16'(ef),    16'd1);
    chk("midrst ff",    16'(ff),    16'd0);
    chk("midrst pae",   16'(pae),   16'd1);
    chk("midrst paf",   16'(paf),   16'd0);
    chk("midrst ovf",   16'(ovf),   16'd0);
    chk("midrst udf",   16'(udf),   16'd0);
    chk("midrst q",     16'(q),     16'd0);
    @(posedge CLK);
    #1;
    RS = 1'b1;
    step(1'b0, 1'b1, 1'b1, 9'h010);
    chk("first write count", 16'(count), 16'd1);
    chk("first write ef",    16'(ef),    16'd0);

    // Offset loads: PAE offset 3, then PAF offset 12 (threshold 4).
    step(1'b0, 1'b1, 1'b0, 9'd3);
    chk("ld pae count", 16'(count), 16'd1);
    step(1'b0, 1'b1, 1'b0, 9'd12);
    chk("ld paf count", 16'(count), 16'd1);
    step(1'b0, 1'b1, 1'b1, 9'h011);
    step(1'b0, 1'b1, 1'b1, 9'h012);
    chk("off c3 count", 16'(count), 16'd3);
    chk("off c3 pae",   16'(pae),   16'd1);
    chk("off c3 paf",   16'(paf),   16'd0);
    step(1'b0, 1'b1, 1'b1, 9'h013);
    chk("off c4 pae",   16'(pae),   16'd0);
    chk("off c4 paf",   16'(paf),   16'd1);
    step(1'b1, 1'b0, 1'b1, 9'h000);
    chk("off rd q",     16'(q),     16'h010);
    chk("off rd pae",   16'(pae),   16'd1);
    chk("off rd paf",   16'(paf),   16'd0);

    // Fill to full (contents 0x011..0x020), then read+write at full.
    for (int i = 0; i < 13; i++) step(1'b0, 1'b1, 1'b1, 9'(9'h014 + i));
    chk("full count", 16'(count), 16'd16);
    chk("full ff",    16'(ff),    16'd1);
    step(1'b0, 1'b0, 1'b1, 9'h1FF);
    chk("simfull count", 16'(count), 16'd15);
    chk("simfull q",     16'(q),     16'h011);
    chk("simfull ff",    16'(ff),    16'd0);
    // The accepted read frees a slot, so the dropped write is not an overflow.
    chk("simfull ovf",   16'(ovf),   16'd0);
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b0, 1'b1, 9'h000);
      chk($sformatf("mid rd%0d q", i), 16'(q), 16'(9'h012 + i));
    end
    chk("mid count", 16'(count), 16'd8);
    step(1'b0, 1'b0, 1'b1, 9'h0EE);
    chk("sim8 count", 16'(count), 16'd8);
    chk("sim8 q",     16'(q),     16'h019);
    chk("sim8 pae",   16'(pae),   16'd0);
    chk("sim8 paf",   16'(paf),   16'd1);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 1'b1, 9'h000);
      chk($sformatf("tail rd%0d q", i), 16'(q), (i == 7) ? 16'h0EE : 16'(9'h01A + i));
    end
    chk("tail ef",  16'(ef),  16'd1);
    chk("tail udf", 16'(udf), 16'd0);

    // FWFT behaviour after a fresh reset.
    RS = 1'b0;
    step(1'b1, 1'b1, 1'b1, 9'h000);
    RS = 1'b1;
    step(1'b0, 1'b1, 1'b1, 9'h0AA);
    chk("fwft q",      16'(qf),     16'h0AA);
    chk("fwft ef",     16'(eff),    16'd0);
    chk("fwft count",  16'(countf), 16'd1);
    chk("std no-ren q", 16'(q),     16'd0);
    step(1'b1, 1'b1, 1'b1, 9'h000);
    chk("fwft hold q", 16'(qf), 16'h0AA);
    OE = 1'b0;
    #1;
    chk("fwft oe q",   16'(qf), 16'd0);
    chk("std oe q",    16'(q),  16'd0);
    OE = 1'b1;
    step(1'b1, 1'b0, 1'b1, 9'h000);
    chk("fwft pop ef",    16'(eff),    16'd1);
    chk("fwft pop count", 16'(countf), 16'd0);
    chk("fwft pop q",     16'(qf),     16'h0AA);
    chk("fwft pop udf",   16'(udff),   16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
